me_sad_scheduler: RTL and testbench

//  Sequences the combinational AD array for full-search block motion estimation.
//  - Per batch: issues current/reference pixel reads, broadcasts one current pixel per cycle, and registers the AD PSAD outputs back into its inputs.
//  - After each batch: scans the PIXELS_IN_BATCH candidate SADs, one per cycle.
//  - Reports the minimum SAD and its candidate index over all NUM_BATCHES batches.
//  - Sits between the pixel memories and the AD array; the AD array itself holds no state.

---
 rtl/me_sad_if.sv | 69 ++++++
 rtl/me_sad_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_me_sad_scheduler.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/me_sad_if.sv
// ---------------------------------------------------------------------------
// me_sad_if
// Bundles the signals between the SAD scheduler, the pixel memories, the
// combinational AD array and the search requester.
//
// Signals
//   start      requester -> scheduler  search request
//   ready      scheduler -> requester  scheduler idle, start will be taken
//   rd_en      scheduler -> memories   read strobe (both memories)
//   pix_addr   scheduler -> memories   row-major pixel index
//   batch_idx  scheduler -> ref memory reference batch select
//   psad_fb    scheduler -> AD array   registered per-lane accumulators
//   psad_ad    AD array  -> scheduler  accumulators + |cur - ref| per lane
//   best_sad   scheduler -> requester  minimum SAD found
//   best_idx   scheduler -> requester  global candidate index of best_sad
//   done       scheduler -> requester  one-cycle result-final pulse
//   cycle_cnt  scheduler -> requester  busy cycle count (ME_CYCLE_CNT_EN only)
//
// Modports: master = scheduler side, slave = environment side.
// Optional feature macro: ME_CYCLE_CNT_EN.
// ---------------------------------------------------------------------------
interface me_sad_if #(
    parameter int PIXELS_IN_BATCH = 16,
    parameter int EDGE_LEN        = 8,
    parameter int NUM_BATCHES     = 4,
    parameter int PSAD_BITS       = 14
);
    localparam int N       = EDGE_LEN * EDGE_LEN;
    localparam int ADDR_W  = (N > 1) ? $clog2(N) : 1;
    localparam int BATCH_W = (NUM_BATCHES > 1) ? $clog2(NUM_BATCHES) : 1;
    localparam int IDX_W   = (PIXELS_IN_BATCH * NUM_BATCHES > 1)
                             ? $clog2(PIXELS_IN_BATCH * NUM_BATCHES) : 1;

    logic                                 start;
    logic                                 ready;
    logic                                 rd_en;
    logic [ADDR_W-1:0]                    pix_addr;
    logic [BATCH_W-1:0]                   batch_idx;
    logic [PSAD_BITS*PIXELS_IN_BATCH-1:0] psad_fb;
    logic [PSAD_BITS*PIXELS_IN_BATCH-1:0] psad_ad;
    logic [PSAD_BITS-1:0]                 best_sad;
    logic [IDX_W-1:0]                     best_idx;
    logic                                 done;
`ifdef ME_CYCLE_CNT_EN
    logic [15:0]                          cycle_cnt;

    modport master (
        input  start, psad_ad,
        output ready, rd_en, pix_addr, batch_idx, psad_fb,
               best_sad, best_idx, done, cycle_cnt
    );
    modport slave (
        output start, psad_ad,
        input  ready, rd_en, pix_addr, batch_idx, psad_fb,
               best_sad, best_idx, done, cycle_cnt
    );
`else
    modport master (
        input  start, psad_ad,
        output ready, rd_en, pix_addr, batch_idx, psad_fb,
               best_sad, best_idx, done
    );
    modport slave (
        output start, psad_ad,
        input  ready, rd_en, pix_addr, batch_idx, psad_fb,
               best_sad, best_idx, done
    );
`endif
endinterface

// File: rtl/me_sad_scheduler.sv
// ---------------------------------------------------------------------------
// me_sad_scheduler
// Sequences a stateless combinational AD array for full-search block motion
// estimation. Each batch streams all N pixels of the current block and of
// PIXELS_IN_BATCH reference candidates through the array, feeding the lane
// accumulators back through registers; then the lane SADs are scanned one per
// cycle and the running minimum is kept across NUM_BATCHES batches.
//
// Ports
//   clk   clock, all logic on the rising edge
//   rst   synchronous active-high reset
//   bus   me_sad_if.master (start/ready, memory read port, AD feedback,
//         result best_sad/best_idx/done, optional cycle_cnt)
//
// Optional feature macro: ME_CYCLE_CNT_EN adds a saturating 16-bit count of
// busy cycles on bus.cycle_cnt.
// ---------------------------------------------------------------------------
module me_sad_scheduler #(
    parameter int PIXELS_IN_BATCH = 16,
    parameter int BIT_DEPTH       = 8,
    parameter int EDGE_LEN        = 8,
    parameter int NUM_BATCHES     = 4,
    parameter int PSAD_BITS       = 14
) (
    input  logic    clk,
    input  logic    rst,
    me_sad_if.master bus
);
    localparam int P       = PIXELS_IN_BATCH;
    localparam int N       = EDGE_LEN * EDGE_LEN;
    localparam int ADDR_W  = (N > 1) ? $clog2(N) : 1;
    localparam int BATCH_W = (NUM_BATCHES > 1) ? $clog2(NUM_BATCHES) : 1;
    localparam int LANE_W  = (P > 1) ? $clog2(P) : 1;
    localparam int IDX_W   = (P * NUM_BATCHES > 1) ? $clog2(P * NUM_BATCHES) : 1;

    // Accumulators must hold N worst-case differences without wrapping.
    generate
        if (PSAD_BITS < BIT_DEPTH + $clog2(N)) begin : g_bad_cfg
            $error("PSAD_BITS too small for BIT_DEPTH and EDGE_LEN");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_SCAN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    pix_q, pix_d;
    logic [LANE_W-1:0]    lane_q, lane_d;
    logic [BATCH_W-1:0]   batch_q, batch_d;
    logic [PSAD_BITS-1:0] best_sad_q, best_sad_d;
    logic [IDX_W-1:0]     best_idx_q, best_idx_d;
    logic                 rd_vld_q;
    logic                 clr_acc;
    logic [PSAD_BITS-1:0] psad_q [P];
    logic [PSAD_BITS-1:0] lane_sad;
    logic [IDX_W-1:0]     cand_idx;

    assign lane_sad = psad_q[lane_q];
    assign cand_idx = IDX_W'(batch_q) * IDX_W'(P) + IDX_W'(lane_q);

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pix_q      <= '0;
            lane_q     <= '0;
            batch_q    <= '0;
            best_sad_q <= '0;
            best_idx_q <= '0;
            rd_vld_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pix_q      <= pix_d;
            lane_q     <= lane_d;
            batch_q    <= batch_d;
            best_sad_q <= best_sad_d;
            best_idx_q <= best_idx_d;
            // Memory data arrives one cycle after the read strobe.
            rd_vld_q   <= (state_q == S_READ);
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        pix_d      = pix_q;
        lane_d     = lane_q;
        batch_d    = batch_q;
        best_sad_d = best_sad_q;
        best_idx_d = best_idx_q;
        clr_acc    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    best_sad_d = '1;
                    best_idx_d = '0;
                    batch_d    = '0;
                    pix_d      = '0;
                    clr_acc    = 1'b1;
                    state_d    = S_READ;
                end
            end
            S_READ: begin
                if (pix_q == ADDR_W'(N - 1)) begin
                    pix_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    pix_d = pix_q + 1'b1;
                end
            end
            S_WAIT: begin
                // The last pixel's PSAD is captured at the end of this cycle.
                lane_d  = '0;
                state_d = S_SCAN;
            end
            S_SCAN: begin
                // Strict compare: on ties the earlier (lower) index survives.
                if (lane_sad < best_sad_q) begin
                    best_sad_d = lane_sad;
                    best_idx_d = cand_idx;
                end
                if (lane_q == LANE_W'(P - 1)) begin
                    lane_d = '0;
                    if (batch_q == BATCH_W'(NUM_BATCHES - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        batch_d = batch_q + 1'b1;
                        pix_d   = '0;
                        clr_acc = 1'b1;
                        state_d = S_READ;
                    end
                end else begin
                    lane_d = lane_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Lane accumulators: cleared on READ entry, loaded from the AD array
    // whenever memory data is valid. Entry into READ never coincides with
    // rd_vld, so clear and load cannot collide.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < P; gi++) begin : g_lane
            always_ff @(posedge clk) begin
                if (rst) begin
                    psad_q[gi] <= '0;
                end else if (clr_acc) begin
                    psad_q[gi] <= '0;
                end else if (rd_vld_q) begin
                    psad_q[gi] <= bus.psad_ad[gi*PSAD_BITS +: PSAD_BITS];
                end
            end
            assign bus.psad_fb[gi*PSAD_BITS +: PSAD_BITS] = psad_q[gi];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.ready     = (state_q == S_IDLE);
    assign bus.rd_en     = (state_q == S_READ);
    assign bus.pix_addr  = pix_q;
    assign bus.batch_idx = batch_q;
    assign bus.best_sad  = best_sad_q;
    assign bus.best_idx  = best_idx_q;
    assign bus.done      = (state_q == S_DONE);

`ifdef ME_CYCLE_CNT_EN
    // cyc_q counts completed busy cycles; the output includes the current
    // busy cycle, so it reads the done cycle number at done and keeps that
    // value through IDLE.
    logic [15:0] cyc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= '0;
        end else if (state_q == S_IDLE) begin
            if (bus.start) begin
                cyc_q <= '0;
            end
        end else if (cyc_q != 16'hFFFF) begin
            cyc_q <= cyc_q + 16'd1;
        end
    end

    assign bus.cycle_cnt = ((state_q != S_IDLE) && (cyc_q != 16'hFFFF))
                           ? cyc_q + 16'd1 : cyc_q;
`endif

endmodule

// File: tb/tb_me_sad_scheduler.sv
module tb_me_sad_scheduler;
    localparam int P  = 16;
    localparam int BD = 8;
    localparam int E  = 8;
    localparam int NB = 4;
    localparam int PB = 14;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   test_mode;
    int   done_cnt;

    me_sad_if #(.PIXELS_IN_BATCH(P), .EDGE_LEN(E), .NUM_BATCHES(NB),
                .PSAD_BITS(PB)) bus ();

    me_sad_scheduler #(.PIXELS_IN_BATCH(P), .BIT_DEPTH(BD), .EDGE_LEN(E),
                       .NUM_BATCHES(NB), .PSAD_BITS(PB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- pixel patterns ----------------
    function automatic logic [7:0] cur_pix(input int p);
        if (test_mode == 2) return 8'd0;
        return 8'(64 + (p * 7) % 100);
    endfunction

    function automatic logic [7:0] ref_pix(input int b, input int l, input int p);
        logic [7:0] c;
        c = cur_pix(p);
        case (test_mode)
            0: return ((b == 2) && (l == 5)) ? c : 8'(int'(c) + 1 + ((b * 3 + l + p) % 4));
            1: return 8'(int'(c) + 10);
            2: return 8'd255;
            3: begin
                if ((b == 3) && (l == 15)) return (p == 0) ? 8'(int'(c) + 1) : c;
                return 8'(int'(c) + 2);
            end
            default: begin
                if ((b == 0) && (l == 0)) return (p < 6) ? 8'(int'(c) + 1) : c;
                if (((b == 1) && (l == 3)) || ((b == 2) && (l == 7)))
                    return (p < 5) ? 8'(int'(c) + 1) : c;
                return 8'(int'(c) + 1);
            end
        endcase
    endfunction

    // ---------------- memory model (1-cycle latency) and AD array ----------------
    logic [7:0] cur_q;
    logic [7:0] ref_q [P];

    always @(posedge clk) begin
        if (bus.rd_en) begin
            cur_q <= cur_pix(int'(bus.pix_addr));
            for (int l = 0; l < P; l++)
                ref_q[l] <= ref_pix(int'(bus.batch_idx), l, int'(bus.pix_addr));
        end
    end

    always_comb begin
        logic [PB*P-1:0] tmp;
        logic [7:0]      d;
        tmp = '0;
        d   = '0;
        for (int l = 0; l < P; l++) begin
            d = (cur_q > ref_q[l]) ? cur_q - ref_q[l] : ref_q[l] - cur_q;
            tmp[l*PB +: PB] = bus.psad_fb[l*PB +: PB] + PB'(d);
        end
        bus.psad_ad = tmp;
    end

    always @(negedge clk) if (bus.done) done_cnt++;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Starts a search from IDLE; returns the cycle (acceptance = 0) at which
    // done was seen, or -1 when the budget ran out, plus the rd_en cycle count.
    task automatic run_search(output int done_cyc, output int rd_cnt);
        int cyc;
        bit found;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        cyc    = 1;
        found  = 0;
        rd_cnt = 0;
        while (cyc < 2000 && !found) begin
            @(negedge clk);
            if (bus.rd_en) rd_cnt++;
            if (bus.done) found = 1;
            else begin
                @(posedge clk);
                cyc++;
            end
        end
        done_cyc = found ? cyc : -1;
    endtask

    typedef struct {
        int mode;
        int exp_sad;
        int exp_idx;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int dc, rc, cyc, nd;
        int dcs[3];
        logic [31:0] hold_sad, hold_idx;

        vecs[0] = '{0, 0,     37};   // exact match at batch 2 lane 5
        vecs[1] = '{1, 640,   0};    // all tie, lowest index wins
        vecs[2] = '{2, 16320, 0};    // worst-case magnitude, no wrap
        vecs[3] = '{3, 1,     63};   // best at the last global index
        vecs[4] = '{4, 5,     19};   // tie between 19 and 39, 19 kept

        n_cmp = 0; n_err = 0; done_cnt = 0; test_mode = 0;
        bus.start = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // ---- reset state ----
        check("rst_ready",    32'(bus.ready), 1);
        check("rst_rd_en",    32'(bus.rd_en), 0);
        check("rst_done",     32'(bus.done), 0);
        check("rst_best_sad", 32'(bus.best_sad), 0);
        check("rst_best_idx", 32'(bus.best_idx), 0);
        check("rst_psad_fb",  32'(bus.psad_fb == '0), 1);
        $display("reset: ready=%0d best_sad=%0d", bus.ready, bus.best_sad);

        // ---- table-driven searches ----
        for (int v = 0; v < 5; v++) begin
            test_mode = vecs[v].mode;
            run_search(dc, rc);
            $display("vec %0d mode %0d: done@%0d rd=%0d sad=%0d idx=%0d",
                     v, vecs[v].mode, dc, rc, bus.best_sad, bus.best_idx);
            check("done_cycle", 32'(dc), 325);
            check("rd_cycles",  32'(rc), NB * E * E);
            check("done_ready", 32'(bus.ready), 0);
            check("best_sad",   32'(bus.best_sad), 32'(vecs[v].exp_sad));
            check("best_idx",   32'(bus.best_idx), 32'(vecs[v].exp_idx));
            hold_sad = 32'(bus.best_sad);
            hold_idx = 32'(bus.best_idx);
            repeat (5) @(negedge clk);
            check("idle_ready", 32'(bus.ready), 1);
            check("idle_done",  32'(bus.done), 0);
            check("hold_sad",   32'(bus.best_sad), hold_sad);
            check("hold_idx",   32'(bus.best_idx), hold_idx);
        end

        // ---- reset during READ of batch 1 ----
        test_mode = 0;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        cyc = 0;
        while (cyc < 500 && !(bus.batch_idx == 1 && bus.rd_en)) begin
            @(negedge clk);
            cyc++;
        end
        check("reach_batch1", 32'(cyc < 500), 1);
        repeat (10) @(negedge clk);
        nd = done_cnt;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ready",  32'(bus.ready), 1);
        check("midrst_psad",   32'(bus.psad_fb == '0), 1);
        check("midrst_rd_en",  32'(bus.rd_en), 0);
        check("midrst_best",   32'(bus.best_sad), 0);
        repeat (400) @(negedge clk);
        check("midrst_nodone", 32'(done_cnt), 32'(nd));
        $display("midrst: ready=%0d done_pulses=%0d", bus.ready, done_cnt - nd);
        run_search(dc, rc);
        $display("after rst: done@%0d sad=%0d idx=%0d", dc, bus.best_sad, bus.best_idx);
        check("rerun_cycle", 32'(dc), 325);
        check("rerun_sad",   32'(bus.best_sad), 0);
        check("rerun_idx",   32'(bus.best_idx), 37);

        // ---- start held high continuously ----
        repeat (3) @(negedge clk);
        dcs = '{-1, -1, -1};
        nd  = 0;
        bus.start = 1'b1;
        @(posedge clk);
        cyc = 1;
        while (cyc < 1100 && nd < 3) begin
            @(negedge clk);
            if (bus.done) begin
                dcs[nd] = cyc;
                nd++;
            end
            @(posedge clk);
            cyc++;
        end
        #1 bus.start = 1'b0;
        $display("held start: done@%0d,%0d,%0d", dcs[0], dcs[1], dcs[2]);
        check("held_count", 32'(nd), 3);
        check("held_done0", 32'(dcs[0]), 325);
        check("held_done1", 32'(dcs[1]), 651);
        check("held_done2", 32'(dcs[2]), 977);
        @(negedge clk);
        check("held_idx",   32'(bus.best_idx), 37);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
